// File: rtl/ghost_pkg.sv
// ghost_pkg: shared types and constants for ghost_chase_ctrl.
// States, move directions and the wall-word helper.
package ghost_pkg;

    typedef enum logic [1:0] {
        S_WAIT,
        S_READ,
        S_DECIDE,
        S_PUBLISH
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP,
        DIR_LEFT,
        DIR_DOWN,
        DIR_RIGHT
    } dir_t;

    // All-ones word of width w marks a wall cell.
    function automatic logic [31:0] wall_word(input int w);
        if (w >= 32)
            return 32'hFFFF_FFFF;
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/ghost_chase_ctrl_dir_select.sv
// ghost_dir_select: picks one ghost's move from four neighbour words.
// Frightened (max-word) selection exists only with GHOST_FRIGHT_EN.
module ghost_dir_select
    import ghost_pkg::*;
#(
    parameter int DIST_W = 8
) (
    input  logic [3:0][DIST_W-1:0] words,
    input  logic [3:0]             prev_mask,
    input  logic                   mode,
    output dir_t                   dir,
    output logic                   stay
);

    localparam logic [DIST_W-1:0] WALL = DIST_W'(wall_word(DIST_W));

    logic [3:0]        open_mask;
    logic [3:0]        cand;
    logic [DIST_W-1:0] best;
    logic              found;

`ifndef GHOST_FRIGHT_EN
    logic unused_mode;
    assign unused_mode = mode;
`endif

    // Mask walls, drop the reverse move unless it is the only way out, pick best.
    always_comb begin
        open_mask = '0;
        for (int i = 0; i < 4; i++)
            open_mask[i] = (words[i] != WALL);
        cand = open_mask & ~prev_mask;
        if (cand == '0)
            cand = open_mask;
        stay  = (open_mask == '0);
        dir   = DIR_UP;
        best  = '0;
        found = 1'b0;
`ifdef GHOST_FRIGHT_EN
        if (mode) begin
            for (int i = 3; i >= 0; i--) begin
                if (cand[i] && (!found || words[i] > best)) begin
                    found = 1'b1;
                    best  = words[i];
                    dir   = dir_t'(2'(i));
                end
            end
        end else
`endif
        begin
            for (int i = 0; i < 4; i++) begin
                if (cand[i] && (!found || words[i] < best)) begin
                    found = 1'b1;
                    best  = words[i];
                    dir   = dir_t'(2'(i));
                end
            end
        end
    end

endmodule

// File: rtl/ghost_chase_ctrl.sv
// ghost_chase_ctrl: reads the distance map around each ghost and publishes moves.
// Optional frightened mode is compiled in with GHOST_FRIGHT_EN.
module ghost_chase_ctrl
    import ghost_pkg::*;
#(
    parameter int NUM_GHOSTS = 2,
    parameter int TICK_MAX   = 50000000,
    parameter int X_W        = 6,
    parameter int Y_W        = 5,
    parameter int DIST_W     = 8
) (
    input  logic                       CLOCK_50,
    input  logic                       reset_n,
    input  logic                       map_ready,
    output logic [X_W-1:0]             rd_x,
    output logic [Y_W-1:0]             rd_y,
    input  logic [DIST_W-1:0]          rd_data,
    input  logic                       wrdone,
    input  logic                       fright,
    input  logic [NUM_GHOSTS*X_W-1:0]  home_x,
    input  logic [NUM_GHOSTS*Y_W-1:0]  home_y,
    output logic [NUM_GHOSTS*X_W-1:0]  curr_x,
    output logic [NUM_GHOSTS*Y_W-1:0]  curr_y,
    output logic [NUM_GHOSTS*X_W-1:0]  next_x,
    output logic [NUM_GHOSTS*Y_W-1:0]  next_y,
    output logic                       next_valid,
    output logic                       busy
);

    localparam int TW = $clog2(TICK_MAX + 1);
    localparam int NR = 4 * NUM_GHOSTS;
    localparam int CW = $clog2(NR + 1);
    localparam logic [TW-1:0] TICK_END = TW'(TICK_MAX - 1);
    localparam logic [CW-1:0] RD_END   = CW'(NR);

    state_t state, state_nx;
    logic [TW-1:0] tick;
    logic [CW-1:0] rd_cnt;
    logic          fright_q;
    logic          tick_done;
    logic          commit;

    logic [NR-1:0][DIST_W-1:0]        words;
    logic [NUM_GHOSTS*X_W-1:0]        prev_x;
    logic [NUM_GHOSTS*Y_W-1:0]        prev_y;
    logic [NUM_GHOSTS-1:0][3:0][X_W-1:0] nb_x;
    logic [NUM_GHOSTS-1:0][3:0][Y_W-1:0] nb_y;
    logic [NUM_GHOSTS-1:0][X_W-1:0]   dec_x;
    logic [NUM_GHOSTS-1:0][Y_W-1:0]   dec_y;

    assign tick_done  = (tick == TICK_END);
    assign commit     = (state == S_PUBLISH) && wrdone;
    assign next_valid = (state == S_PUBLISH);
    assign busy       = (state == S_READ) || (state == S_DECIDE);

    for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_ghost
        logic [X_W-1:0] cx, px;
        logic [Y_W-1:0] cy, py;
        logic [3:0]     pmask;
        dir_t           dir;
        logic           stay;

        assign cx = curr_x[g*X_W +: X_W];
        assign cy = curr_y[g*Y_W +: Y_W];
        assign px = prev_x[g*X_W +: X_W];
        assign py = prev_y[g*Y_W +: Y_W];

        // Neighbours wrap at the map edges (tunnels).
        assign nb_x[g] = {cx + X_W'(1), cx, cx - X_W'(1), cx};
        assign nb_y[g] = {cy, cy + Y_W'(1), cy, cy - Y_W'(1)};

        for (genvar d = 0; d < 4; d++) begin : g_mask
            assign pmask[d] = (nb_x[g][d] == px) && (nb_y[g][d] == py);
        end

        ghost_dir_select #(
            .DIST_W(DIST_W)
        ) u_sel (
            .words    (words[g*4 +: 4]),
            .prev_mask(pmask),
            .mode     (fright_q),
            .dir      (dir),
            .stay     (stay)
        );

        assign dec_x[g] = stay ? cx : nb_x[g][dir];
        assign dec_y[g] = stay ? cy : nb_y[g][dir];
    end

    // Map read address: one neighbour per cycle while reading.
    always_comb begin
        rd_x = '0;
        rd_y = '0;
        if (state == S_READ) begin
            for (int g = 0; g < NUM_GHOSTS; g++) begin
                for (int d = 0; d < 4; d++) begin
                    if (rd_cnt == CW'(4*g + d)) begin
                        rd_x = nb_x[g][d];
                        rd_y = nb_y[g][d];
                    end
                end
            end
        end
    end

    // State register.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n)
            state <= S_WAIT;
        else
            state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_WAIT:
                if (tick_done && map_ready)
                    state_nx = S_READ;
            S_READ:
                if (!map_ready)
                    state_nx = S_WAIT;
                else if (rd_cnt == RD_END)
                    state_nx = S_DECIDE;
            S_DECIDE:
                state_nx = S_PUBLISH;
            S_PUBLISH:
                if (wrdone)
                    state_nx = S_WAIT;
            default:
                state_nx = S_WAIT;
        endcase
    end

    // Tick, read capture, decision and commit registers.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            tick     <= '0;
            rd_cnt   <= '0;
            fright_q <= 1'b0;
            words    <= '0;
            curr_x   <= home_x;
            curr_y   <= home_y;
            next_x   <= home_x;
            next_y   <= home_y;
            prev_x   <= home_x;
            prev_y   <= home_y;
        end else begin
            if (state == S_WAIT && !tick_done)
                tick <= tick + TW'(1);
            if (commit)
                tick <= '0;
            if (state == S_READ)
                rd_cnt <= rd_cnt + CW'(1);
            else
                rd_cnt <= '0;
            if (state == S_WAIT && state_nx == S_READ)
                fright_q <= fright;
            if (state == S_READ) begin
                for (int k = 0; k < NR; k++)
                    if (rd_cnt == CW'(k + 1))
                        words[k] <= rd_data;
            end
            if (state == S_DECIDE) begin
                for (int g = 0; g < NUM_GHOSTS; g++) begin
                    next_x[g*X_W +: X_W] <= dec_x[g];
                    next_y[g*Y_W +: Y_W] <= dec_y[g];
                end
            end
            if (commit) begin
                prev_x <= curr_x;
                prev_y <= curr_y;
                curr_x <= next_x;
                curr_y <= next_y;
            end
        end
    end

endmodule

// File: tb/tb_ghost_chase_ctrl.sv
// tb_ghost_chase_ctrl: directed and random rounds checked against a move model.
// Expectations follow GHOST_FRIGHT_EN when it is defined for the build.
module tb_ghost_chase_ctrl;

    localparam int NG = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        map_ready;
    logic [5:0]  rd_x;
    logic [4:0]  rd_y;
    logic [7:0]  rd_data = 8'd0;
    logic        wrdone;
    logic        fright;
    logic [11:0] home_x, curr_x, next_x;
    logic [9:0]  home_y, curr_y, next_y;
    logic        next_valid, busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] map_mem [64][32];
    int mx[NG], my[NG], px[NG], py[NG], nx[NG], ny[NG];
    int hx[NG], hy[NG];
    bit fr_round;

    ghost_chase_ctrl #(
        .NUM_GHOSTS(NG), .TICK_MAX(4), .X_W(6), .Y_W(5), .DIST_W(8)
    ) dut (
        .CLOCK_50  (clk),
        .reset_n   (reset_n),
        .map_ready (map_ready),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .rd_data   (rd_data),
        .wrdone    (wrdone),
        .fright    (fright),
        .home_x    (home_x),
        .home_y    (home_y),
        .curr_x    (curr_x),
        .curr_y    (curr_y),
        .next_x    (next_x),
        .next_y    (next_y),
        .next_valid(next_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // One-cycle-latency distance map.
    always @(posedge clk) rd_data <= map_mem[rd_x][rd_y];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] pkx(input int a0, input int a1);
        return {6'(a1), 6'(a0)};
    endfunction

    function automatic logic [9:0] pky(input int a0, input int a1);
        return {5'(a1), 5'(a0)};
    endfunction

    task automatic setw(input int x, input int y, input int v);
        map_mem[x & 63][y & 31] = 8'(v);
    endtask

    function automatic int rnd_word();
        if ($urandom_range(0, 3) == 0)
            return 255;
        return int'($urandom_range(0, 12));
    endfunction

    task automatic rnd_nbrs(input int g);
        setw(mx[g], my[g] - 1, rnd_word());
        setw(mx[g] - 1, my[g], rnd_word());
        setw(mx[g], my[g] + 1, rnd_word());
        setw(mx[g] + 1, my[g], rnd_word());
    endtask

    task automatic model_home();
        for (int g = 0; g < NG; g++) begin
            mx[g] = hx[g]; my[g] = hy[g];
            px[g] = hx[g]; py[g] = hy[g];
            nx[g] = hx[g]; ny[g] = hy[g];
        end
    endtask

    // Chase: lowest word, earliest of up/left/down/right wins ties.
    // Fright: highest word, earliest of right/down/left/up wins ties.
    task automatic model_decide(input bit mode);
        for (int g = 0; g < NG; g++) begin
            int bx[4], by[4], w[4];
            bit open[4], cand[4];
            int n_cand, best;
            bx[0] = mx[g];            by[0] = (my[g] + 31) % 32;
            bx[1] = (mx[g] + 63) % 64; by[1] = my[g];
            bx[2] = mx[g];            by[2] = (my[g] + 1) % 32;
            bx[3] = (mx[g] + 1) % 64;  by[3] = my[g];
            n_cand = 0;
            for (int k = 0; k < 4; k++) begin
                w[k]    = int'(map_mem[bx[k]][by[k]]);
                open[k] = (w[k] != 255);
                cand[k] = open[k] && !(bx[k] == px[g] && by[k] == py[g]);
                if (cand[k]) n_cand++;
            end
            if (n_cand == 0) cand = open;
            best = -1;
            if (!mode) begin
                for (int k = 0; k < 4; k++)
                    if (cand[k] && (best < 0 || w[k] < w[best])) best = k;
            end else begin
                for (int k = 3; k >= 0; k--)
                    if (cand[k] && (best < 0 || w[k] > w[best])) best = k;
            end
            if (best < 0) begin
                nx[g] = mx[g]; ny[g] = my[g];
            end else begin
                nx[g] = bx[best]; ny[g] = by[best];
            end
        end
    endtask

    task automatic wait_busy();
        int n = 0;
        while (busy !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("busy_wait", 32'(busy), 32'd1);
    endtask

    task automatic wait_pub();
        int n = 0;
        while (next_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("publish_wait", 32'(next_valid), 32'd1);
    endtask

    task automatic check_next(input string tag);
`ifdef GHOST_FRIGHT_EN
        model_decide(fr_round);
`else
        model_decide(1'b0);
`endif
        chk({tag, "_next_x"}, 32'(next_x), 32'(pkx(nx[0], nx[1])));
        chk({tag, "_next_y"}, 32'(next_y), 32'(pky(ny[0], ny[1])));
    endtask

    task automatic do_commit(input string tag);
        wrdone = 1'b1;
        @(negedge clk);
        wrdone = 1'b0;
        for (int g = 0; g < NG; g++) begin
            px[g] = mx[g]; py[g] = my[g];
            mx[g] = nx[g]; my[g] = ny[g];
        end
        chk({tag, "_curr_x"}, 32'(curr_x), 32'(pkx(mx[0], mx[1])));
        chk({tag, "_curr_y"}, 32'(curr_y), 32'(pky(my[0], my[1])));
        chk({tag, "_valid_clr"}, 32'(next_valid), 32'd0);
    endtask

    task automatic round(input string tag);
        wait_pub();
        check_next(tag);
        do_commit(tag);
    endtask

    initial begin
        int exp_rx[8];
        int exp_ry[8];
        exp_rx = '{16, 15, 16, 17, 23, 22, 23, 24};
        exp_ry = '{12, 13, 14, 13, 12, 13, 14, 13};

        reset_n = 1'b0; map_ready = 1'b1; wrdone = 1'b0; fright = 1'b0;
        fr_round = 1'b0;
        hx = '{16, 23}; hy = '{13, 13};
        home_x = pkx(hx[0], hx[1]);
        home_y = pky(hy[0], hy[1]);
        for (int x = 0; x < 64; x++)
            for (int y = 0; y < 32; y++)
                map_mem[x][y] = 8'(rnd_word());
        model_home();
        setw(16, 12, 5); setw(15, 13, 3); setw(16, 14, 3); setw(17, 13, 9);

        repeat (2) @(negedge clk);
        chk("rst_curr_x", 32'(curr_x), 32'(home_x));
        chk("rst_next_y", 32'(next_y), 32'(home_y));
        chk("rst_valid", 32'(next_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd", {21'd0, rd_x, rd_y}, 32'd0);

        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_read_busy", 32'(busy), 32'd0);
        chk("rel_next_x", 32'(next_x), 32'(home_x));
        @(negedge clk);
        chk("read_entry", 32'(busy), 32'd1);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("rd_x%0d", k), 32'(rd_x), 32'(exp_rx[k]));
            chk($sformatf("rd_y%0d", k), 32'(rd_y), 32'(exp_ry[k]));
            @(negedge clk);
        end

        round("tie");
        chk("tie_ghost0", 32'(curr_x[5:0]), 32'd15);

        setw(15, 12, 255); setw(14, 13, 255); setw(15, 14, 255);
        setw(16, 13, 7);
        round("reverse");
        chk("reverse_ghost0", 32'(curr_x[5:0]), 32'd16);

        setw(16, 12, 255); setw(15, 13, 255);
        setw(16, 14, 255); setw(17, 13, 255);
        round("boxed");
        chk("boxed_ghost0", 32'(curr_x[5:0]), 32'd16);

        setw(16, 12, 5); setw(15, 13, 3); setw(16, 14, 3); setw(17, 13, 9);
        fright = 1'b1; fr_round = 1'b1;
        wait_busy();
        fright = 1'b0;
        wait_pub();
        check_next("fright");
`ifdef GHOST_FRIGHT_EN
        chk("fright_ghost0", 32'(next_x[5:0]), 32'd17);
`else
        chk("fright_ghost0", 32'(next_x[5:0]), 32'd15);
`endif
        do_commit("fright");
        fr_round = 1'b0;

        rnd_nbrs(0); rnd_nbrs(1);
        wait_busy();
        repeat (2) @(negedge clk);
        map_ready = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(next_valid), 32'd0);
        chk("abort_curr", 32'(curr_x), 32'(pkx(mx[0], mx[1])));
        chk("abort_next", 32'(next_y), 32'(pky(ny[0], ny[1])));
        wrdone = 1'b1;
        @(negedge clk);
        wrdone = 1'b0;
        chk("stray_wrdone", 32'(curr_y), 32'(pky(my[0], my[1])));
        map_ready = 1'b1;
        @(negedge clk);
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_rd_y", 32'(rd_y), 32'((my[0] + 31) % 32));
        round("after_abort");

        rnd_nbrs(0); rnd_nbrs(1);
        wait_pub();
        reset_n = 1'b0;
        #1;
        chk("pubrst_curr_x", 32'(curr_x), 32'(home_x));
        chk("pubrst_next_y", 32'(next_y), 32'(home_y));
        chk("pubrst_valid", 32'(next_valid), 32'd0);

        hx = '{0, int'($urandom_range(20, 40))};
        hy = '{10, int'($urandom_range(0, 31))};
        home_x = pkx(hx[0], hx[1]);
        home_y = pky(hy[0], hy[1]);
        repeat (2) @(negedge clk);
        model_home();
        setw(0, 9, 255); setw(63, 10, 1); setw(0, 11, 255); setw(1, 10, 255);
        rnd_nbrs(1);
        reset_n = 1'b1;
        round("tunnel");
        chk("tunnel_x", 32'(curr_x[5:0]), 32'd63);
        chk("tunnel_y", 32'(curr_y[4:0]), 32'd10);

        for (int r = 0; r < 12; r++) begin
            fr_round = 1'($urandom_range(0, 1));
            fright = fr_round;
            rnd_nbrs(0); rnd_nbrs(1);
            round($sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ghost_chase_ctrl.md
GHOST_CHASE_CTRL -- requirements
Module: ghost_chase_ctrl

Interface
REQ-001 Parameter NUM_GHOSTS, default 2: number of ghosts evaluated per move round (1..8).
REQ-002 Parameter TICK_MAX, default 50000000: CLOCK_50 cycles between move rounds.
REQ-003 Parameter X_W, default 6: x-coordinate width.
REQ-004 Parameter Y_W, default 5: y-coordinate width.
REQ-005 Parameter DIST_W, default 8: distance-map word width; all-ones marks a wall.
REQ-006 CLOCK_50  in  1  sole clock; all state rises on its posedge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 map_ready  in  1  distance map is valid for the current pacman position.
REQ-009 rd_x / rd_y  out  X_W / Y_W  distance-map read address.
REQ-010 rd_data  in  DIST_W  map word; valid exactly 1 cycle after its address.
REQ-011 wrdone  in  1  single-cycle pulse: the renderer has drawn the published move.
REQ-012 fright  in  1  frightened mode request; used only when GHOST_FRIGHT_EN is defined.
REQ-013 home_x / home_y  in  NUM_GHOSTS*X_W / NUM_GHOSTS*Y_W  packed spawn coordinates, ghost 0 in the LSBs.
REQ-014 curr_x / curr_y  out  NUM_GHOSTS*X_W / NUM_GHOSTS*Y_W  committed ghost positions.
REQ-015 next_x / next_y  out  NUM_GHOSTS*X_W / NUM_GHOSTS*Y_W  published next positions.
REQ-016 next_valid  out  1  next_* holds an uncommitted move.
REQ-017 busy  out  1  high in S_READ and S_DECIDE.

Function
REQ-018 FSM states: S_WAIT, S_READ, S_DECIDE, S_PUBLISH.
REQ-019 S_WAIT: tick counter runs 0..TICK_MAX-1 and holds at TICK_MAX-1; go to S_READ when the counter is at TICK_MAX-1 and map_ready=1.
REQ-020 S_READ: one address per cycle, ghost 0 to NUM_GHOSTS-1, order per ghost up(y-1), left(x-1), down(y+1), right(x+1); S_READ lasts 4*NUM_GHOSTS+1 cycles to capture the final return.
REQ-021 Neighbour coordinates are computed modulo 2^X_W / 2^Y_W (tunnel wrap): x=0 left gives x=2^X_W-1.
REQ-022 A candidate is excluded if its word is all-ones (wall).
REQ-023 A candidate equal to the ghost's previous position is excluded unless it is the only non-wall candidate.
REQ-024 Chase selection: minimum word among the remaining candidates; ties are resolved by priority up > left > down > right.
REQ-025 If every candidate is a wall, next equals curr for that ghost.
REQ-026 S_DECIDE lasts 1 cycle: registers next_* for all ghosts, then goes to S_PUBLISH.
REQ-027 S_PUBLISH: next_valid=1; on wrdone, prev<=curr, curr<=next, next_valid<=0, tick counter cleared, go to S_WAIT.
REQ-028 wrdone outside S_PUBLISH is ignored; no state changes.
REQ-029 map_ready dropping during S_READ aborts the round: return to S_WAIT, keep the tick counter at TICK_MAX-1, discard partial reads.
REQ-030 fright is sampled once on entry to S_READ and held for the whole round.

Reset
REQ-031 While reset_n=0: state S_WAIT, tick counter 0, curr=next=prev=home per ghost, next_valid=0, busy=0, rd_x=rd_y=0.
REQ-032 Reset asserted mid-round discards the round entirely; no partial commit occurs.

Configuration
REQ-033 Macro GHOST_FRIGHT_EN defined: when the sampled fright=1, selection is the maximum non-wall word, with tie priority right > down > left > up.
REQ-034 GHOST_FRIGHT_EN undefined: the fright port exists but is unused, and selection is always chase.

Structure
REQ-035 Package ghost_pkg holds: the state enum, the direction enum {DIR_UP, DIR_LEFT, DIR_DOWN, DIR_RIGHT}, and the wall constant function of DIST_W.
REQ-036 Sub-module ghost_dir_select: combinational selection for one ghost (four words, previous-position mask, mode in; direction and stay flag out), instantiated NUM_GHOSTS times.

Verification
Bench settings: TICK_MAX=4, NUM_GHOSTS=2, 1-cycle-latency map model.
REQ-037 Reset with home (16,13),(23,13), then release with map_ready=1 -> curr=next=home, next_valid=0; S_READ entered after 4 cycles; rd sequence (16,12),(15,13),(16,14),(17,13),(23,12)...
REQ-038 Ghost 0 words up=5, left=3, down=3, right=9 -> next0=(15,13) by tie priority; wrdone -> curr0=(15,13), prev0=(16,13).
REQ-039 Ghost 0 at x=0, left word=1, others wall -> next0=(63,y) via tunnel wrap.
REQ-040 Only non-wall neighbour is the previous position -> ghost reverses; all four neighbours wall -> next=curr.
REQ-041 GHOST_FRIGHT_EN defined, fright=1, words 5/3/3/9 -> next0 is the right neighbour (17,13); macro undefined -> (15,13).
REQ-042 map_ready dropped mid-S_READ -> back to S_WAIT with no output change; reset_n pulsed in S_PUBLISH -> all ghosts at home, next_valid=0.
